lane_sched: RTL and testbench

LANE_SCHED -- requirements
Module: lane_sched

---
 rtl/lane_sched_if.sv | 33 +++
 rtl/lane_sched.sv | 188 ++++++++++++++++++
 tb/tb_lane_sched.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_sched_if.sv
// Handshake bundle between the two vehicle lanes, the shared pattern
// detector and the per-lane hit counters of lane_sched.
interface lane_sched_if;
  // lane inputs and acks
  logic       req0;
  logic       req1;
  logic       d0;
  logic       d1;
  logic       ack0;
  logic       ack1;
  // detector feed
  logic       valid_out;
  logic       d_out;
  logic       lane_out;
  logic       det_clr;
  // detector result and hit counters
  logic       hit_in;
  logic       cnt_clr;
  logic [7:0] hit_cnt0;
  logic [7:0] hit_cnt1;

  // environment side: presents vehicles, returns detector hits
  modport master (
    output req0, req1, d0, d1, hit_in, cnt_clr,
    input  ack0, ack1, valid_out, d_out, lane_out, det_clr, hit_cnt0, hit_cnt1
  );

  // scheduler side
  modport slave (
    input  req0, req1, d0, d1, hit_in, cnt_clr,
    output ack0, ack1, valid_out, d_out, lane_out, det_clr, hit_cnt0, hit_cnt1
  );
endinterface

// File: rtl/lane_sched.sv
// Two-lane vehicle scheduler feeding one shared pattern detector.
// Lanes are served in bursts of at most BURST vehicles while the other lane
// waits; every switch of source lane inserts one CLR cycle whose registered
// echo (det_clr) wipes the detector context. Detector hits are attributed
// back to the lane whose item produced them.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no lane granted; pick the next lane when anyone requests
// GRANT0 | lane 0 owns the detector; ack0 follows req0
// GRANT1 | lane 1 owns the detector; ack1 follows req1
// CLR    | one dead cycle before handing the detector to lane tgt
module lane_sched #(
  parameter int unsigned BURST = 4,
  parameter logic        B     = 1'b0,
  parameter logic        C     = 1'b1
) (
  input logic         clk,
  input logic         rst,
  lane_sched_if.slave bus
);

  if (BURST < 1 || BURST > 15) begin : g_burst_check
    $error("lane_sched: BURST must be in 1..15");
  end
  if (B == C) begin : g_code_check
    $error("lane_sched: vehicle codes B and C must differ");
  end

  localparam logic [3:0] BURST_C = 4'(BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10,
    CLR    = 2'b11
  } state_t;

  state_t     state;
  logic       last_lane;
  logic       ctx_vld;
  logic [3:0] bcnt;
  logic       tgt;

  logic       valid_r;
  logic       d_r;
  logic       lane_r;
  logic       det_clr_r;
  logic       lane_d;
  logic [7:0] hit_cnt0_r;
  logic [7:0] hit_cnt1_r;

  logic       ack0_c;
  logic       ack1_c;
  logic       acc;
  logic       acc_d;
  logic       acc_lane;
  logic       cur_lane;
  logic       cur_req;
  logic       oth_req;
  logic       any_req;
  logic       alt_req;
  logic       sel_lane;
  logic [3:0] bcnt_inc;

  // Acks are a pure function of the grant state; reset kills them at once
  // so a vehicle presented across reset is never consumed.
  always_comb begin
    ack0_c = 1'b0;
    ack1_c = 1'b0;
    if (!rst) begin
      if (state == GRANT0) ack0_c = bus.req0;
      if (state == GRANT1) ack1_c = bus.req1;
    end
  end

  // Accepted-item mux plus the lane-selection helpers used by the FSM.
  always_comb begin
    acc      = ack0_c | ack1_c;
    acc_lane = ack1_c;
    acc_d    = ack1_c ? bus.d1 : bus.d0;
    cur_lane = (state == GRANT1);
    cur_req  = cur_lane ? bus.req1 : bus.req0;
    oth_req  = cur_lane ? bus.req0 : bus.req1;
    any_req  = bus.req0 | bus.req1;
    // prefer the lane that was not served last, for fairness out of IDLE
    alt_req  = last_lane ? bus.req0 : bus.req1;
    sel_lane = alt_req ? ~last_lane : last_lane;
    bcnt_inc = bcnt + 4'd1;
  end

  // Grant FSM: burst accounting, lane switching and context tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_lane <= 1'b1;
      ctx_vld   <= 1'b0;
      bcnt      <= 4'd0;
      tgt       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bcnt <= 4'd0;
          if (any_req) begin
            // a fresh detector or the same lane needs no context wipe
            if (!ctx_vld || (sel_lane == last_lane)) begin
              state <= sel_lane ? GRANT1 : GRANT0;
            end else begin
              state <= CLR;
              tgt   <= sel_lane;
            end
          end
        end
        GRANT0, GRANT1: begin
          if (!cur_req) begin
            bcnt <= 4'd0;
            if (oth_req) begin
              state <= CLR;
              tgt   <= ~cur_lane;
            end else begin
              state <= IDLE;
            end
          end else begin
            ctx_vld   <= 1'b1;
            last_lane <= cur_lane;
            if (bcnt_inc == BURST_C) begin
              // burst only ends the grant if someone is waiting
              bcnt <= 4'd0;
              if (oth_req) begin
                state <= CLR;
                tgt   <= ~cur_lane;
              end
            end else begin
              bcnt <= bcnt_inc;
            end
          end
        end
        CLR: begin
          bcnt  <= 4'd0;
          state <= tgt ? GRANT1 : GRANT0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Detector feed: one-cycle registered copy of the accepted vehicle, and
  // the context-clear pulse that echoes the CLR state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= 1'b0;
      d_r       <= 1'b0;
      lane_r    <= 1'b0;
      det_clr_r <= 1'b0;
      lane_d    <= 1'b0;
    end else begin
      valid_r   <= acc;
      det_clr_r <= (state == CLR);
      // lane_d names the lane of the item the detector is answering for now
      lane_d    <= lane_r;
      if (acc) begin
        d_r    <= acc_d;
        lane_r <= acc_lane;
      end
    end
  end

  // Saturating per-lane hit counters; clear wins over a simultaneous hit.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      hit_cnt0_r <= 8'd0;
      hit_cnt1_r <= 8'd0;
    end else if (bus.hit_in) begin
      if (!lane_d && (hit_cnt0_r != 8'hFF)) hit_cnt0_r <= hit_cnt0_r + 8'd1;
      if (lane_d && (hit_cnt1_r != 8'hFF))  hit_cnt1_r <= hit_cnt1_r + 8'd1;
    end
  end

  assign bus.ack0      = ack0_c;
  assign bus.ack1      = ack1_c;
  assign bus.valid_out = valid_r;
  assign bus.d_out     = d_r;
  assign bus.lane_out  = lane_r;
  assign bus.det_clr   = det_clr_r;
  assign bus.hit_cnt0  = hit_cnt0_r;
  assign bus.hit_cnt1  = hit_cnt1_r;

endmodule

// File: tb/tb_lane_sched.sv
// Scoreboard bench for lane_sched: lane models present queued vehicles, the
// hand-derived output order is queued up front, and a monitor checks every
// valid_out item against it.
module tb_lane_sched;

  localparam logic VB = 1'b0;
  localparam logic VC = 1'b1;

  typedef struct packed {
    logic lane;
    logic d;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lane_sched_if bus ();

  lane_sched #(.BURST(4), .B(VB), .C(VC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic  lq0[$];
  logic  lq1[$];
  item_t expq[$];

  int total = 0;
  int bad = 0;
  int det_cnt = 0;
  int run = 0;
  int max_run = 0;
  int pop0 = 0;
  int pop1 = 0;
  bit mon_en = 0;
  bit hit_force = 0;
  bit clr_force = 0;
  bit hit_on_clr = 0;

  task automatic check(string name, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic add(logic lane, logic d);
    if (lane) lq1.push_back(d);
    else      lq0.push_back(d);
  endtask

  task automatic push_exp(logic lane, logic d);
    item_t it;
    it.lane = lane;
    it.d    = d;
    expq.push_back(it);
  endtask

  task automatic drive_lanes();
    bus.req0 = (lq0.size() != 0);
    bus.d0   = (lq0.size() != 0) ? lq0[0] : 1'b0;
    bus.req1 = (lq1.size() != 0);
    bus.d1   = (lq1.size() != 0) ? lq1[0] : 1'b0;
  endtask

  // one clock: sample acks mid-cycle, consume on the edge, redrive after it
  task automatic step();
    logic a0;
    logic a1;
    bit   hc;
    @(negedge clk);
    a0 = bus.ack0;
    a1 = bus.ack1;
    @(posedge clk);
    #1;
    if (a0 && lq0.size() != 0) begin
      void'(lq0.pop_front());
      pop0++;
    end
    if (a1 && lq1.size() != 0) begin
      void'(lq1.pop_front());
      pop1++;
    end
    drive_lanes();
    hc = hit_on_clr && bus.det_clr;
    if (hc) hit_on_clr = 0;
    bus.hit_in  = hit_force || hc;
    bus.cnt_clr = clr_force;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("ack0_in_rst", int'(bus.ack0), 0);
    check("ack1_in_rst", int'(bus.ack1), 0);
    rst = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((lq0.size() != 0 || lq1.size() != 0 || expq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_left", lq0.size() + lq1.size() + expq.size(), 0);
    repeat (3) step();
  endtask

  // monitor: scoreboard compare plus per-cycle protocol checks
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.ack0 || bus.ack1) check("ack_excl", int'(bus.ack0 && bus.ack1), 0);
        if (bus.det_clr) begin
          det_cnt++;
          check("valid_in_detclr", int'(bus.valid_out), 0);
        end
        if (bus.valid_out) begin
          run++;
          if (run > max_run) max_run = run;
          total++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL item_unexpected lane_out=%0d d_out=%0d", bus.lane_out, bus.d_out);
          end else begin
            e = expq.pop_front();
            if (e.lane != bus.lane_out || e.d != bus.d_out) begin
              bad++;
              $display("FAIL item lane_out=%0d d_out=%0d want lane=%0d d=%0d",
                       bus.lane_out, bus.d_out, e.lane, e.d);
            end
          end
        end else begin
          run = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seq1 [5] = '{VB, VB, VC, VB, VC};
    int   det_base;
    int   n;

    bus.req0 = 0; bus.req1 = 0; bus.d0 = 0; bus.d1 = 0;
    bus.hit_in = 0; bus.cnt_clr = 0;

    // reset state
    do_reset();
    mon_en = 1;
    check("rst_valid", int'(bus.valid_out), 0);
    check("rst_detclr", int'(bus.det_clr), 0);
    check("rst_lane_out", int'(bus.lane_out), 0);
    check("rst_d_out", int'(bus.d_out), 0);
    check("rst_cnt0", int'(bus.hit_cnt0), 0);
    check("rst_cnt1", int'(bus.hit_cnt1), 0);

    // single lane 0 stream B,B,C,B,C then one hit
    det_base = det_cnt;
    max_run = 0;
    for (int i = 0; i < 5; i++) begin
      add(0, seq1[i]);
      push_exp(0, seq1[i]);
    end
    drain(60);
    check("s1_run", max_run, 5);
    check("s1_detclr", det_cnt - det_base, 0);
    hit_force = 1;
    step();
    hit_force = 0;
    step();
    step();
    check("s1_cnt0", int'(bus.hit_cnt0), 1);
    check("s1_cnt1", int'(bus.hit_cnt1), 0);

    // both lanes busy: bursts of 4 alternate, lane 0 first, no leading CLR
    do_reset();
    det_base = det_cnt;
    for (int i = 0; i < 8; i++) begin
      add(0, 1'(i % 2));
      add(1, 1'((i % 3) == 0));
    end
    for (int i = 0; i < 4; i++) push_exp(0, 1'(i % 2));
    for (int i = 0; i < 4; i++) push_exp(1, 1'((i % 3) == 0));
    for (int i = 4; i < 8; i++) push_exp(0, 1'(i % 2));
    for (int i = 4; i < 8; i++) push_exp(1, 1'((i % 3) == 0));
    drain(100);
    check("s2_detclr", det_cnt - det_base, 3);

    // lane 0 alone runs past BURST; lane 1 arrives after 10 and waits for
    // the burst to close; a hit in the det_clr cycle belongs to lane 0
    do_reset();
    det_base = det_cnt;
    pop0 = 0;
    hit_on_clr = 1;
    for (int i = 0; i < 14; i++) add(0, 1'((i % 4) == 1));
    for (int i = 0; i < 12; i++) push_exp(0, 1'((i % 4) == 1));
    for (int i = 0; i < 4; i++) push_exp(1, 1'(i < 2));
    for (int i = 12; i < 14; i++) push_exp(0, 1'((i % 4) == 1));
    n = 0;
    while (pop0 < 10 && n < 100) begin
      step();
      n++;
    end
    check("s3_pop10", pop0, 10);
    check("s3_no_clr", det_cnt - det_base, 0);
    for (int i = 0; i < 4; i++) add(1, 1'(i < 2));
    drive_lanes();
    drain(100);
    check("s3_detclr", det_cnt - det_base, 2);
    check("s3_cnt0", int'(bus.hit_cnt0), 1);
    check("s3_cnt1", int'(bus.hit_cnt1), 0);
    check("s3_hit_used", int'(hit_on_clr), 0);

    // one lane 1 item after lane 0 context forces a CLR, then saturate lane 1
    det_base = det_cnt;
    add(1, VC);
    push_exp(1, VC);
    drain(40);
    check("s4_detclr", det_cnt - det_base, 1);
    hit_force = 1;
    repeat (255) step();
    hit_force = 0;
    step();
    step();
    check("s4_cnt1_255", int'(bus.hit_cnt1), 255);
    hit_force = 1;
    repeat (45) step();
    hit_force = 0;
    step();
    step();
    check("s4_cnt1_sat", int'(bus.hit_cnt1), 255);
    check("s4_cnt0", int'(bus.hit_cnt0), 1);

    // clear beats a simultaneous hit
    hit_force = 1;
    clr_force = 1;
    step();
    hit_force = 0;
    clr_force = 0;
    step();
    step();
    check("s5_cnt0", int'(bus.hit_cnt0), 0);
    check("s5_cnt1", int'(bus.hit_cnt1), 0);

    // reset mid-burst on lane 1: ack drops at once, held vehicle survives,
    // lane 0 is then chosen without a CLR
    do_reset();
    det_base = det_cnt;
    pop1 = 0;
    for (int i = 0; i < 5; i++) add(1, 1'(i == 2 || i == 3));
    push_exp(1, 1'b0);
    push_exp(1, 1'b0);
    n = 0;
    while (pop1 < 2 && n < 50) begin
      step();
      n++;
    end
    check("s6_pop2", pop1, 2);
    rst = 1'b1;
    #1;
    check("s6_ack1_rst", int'(bus.ack1), 0);
    check("s6_req1_held", int'(bus.req1), 1);
    add(0, VC);
    add(0, VB);
    push_exp(0, VC);
    push_exp(0, VB);
    push_exp(1, 1'b1);
    push_exp(1, 1'b1);
    push_exp(1, 1'b0);
    step();
    step();
    rst = 1'b0;
    check("s6_rst_valid", int'(bus.valid_out), 0);
    drain(60);
    check("s6_detclr", det_cnt - det_base, 1);
    check("s6_pop1", pop1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
